// File: rtl/mips_multiciclo_if.sv
// Word-addressed memory port shared by the multicycle core (master) and its memory (slave).
// A request is held until the cycle in which mem_ready is seen, and it completes in that cycle.
interface mips_multiciclo_if #(
    parameter int ADDR_W = 10
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              mem_ready;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/mips_multiciclo.sv
// Multicycle MIPS subset core (add/sub/and/or/slt, lw, sw, addi, beq, j) with one unified memory port.
// All bus outputs are registered; they are set up on the edge that enters FETCH or MEM.
module mips_multiciclo #(
    parameter int          ADDR_W       = 10,
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter bit          SUPPORT_ADDI = 1'b1
) (
    input  logic                clock,
    input  logic                reset_n,
    mips_multiciclo_if.master   mem,
    output logic [31:0]         pc_out,
    output logic                halted
);
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] ir;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] alu_out;
    logic [31:0] mdr;
    logic [31:0] rf [32];
    logic [4:0]  dest;

    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [5:0]  funct;
    logic [31:0] imm_ext;
    logic [31:0] eff_addr;
    logic [31:0] branch_pc;
    logic [31:0] jump_pc;
    logic [31:0] r_result;
    logic        r_valid;

    assign opcode    = ir[31:26];
    assign rs        = ir[25:21];
    assign rt        = ir[20:16];
    assign rd        = ir[15:11];
    assign funct     = ir[5:0];
    assign imm_ext   = {{16{ir[15]}}, ir[15:0]};
    assign eff_addr  = a + imm_ext;
    assign branch_pc = (a == b) ? alu_out : pc;
    assign jump_pc   = {pc[31:28], ir[25:0], 2'b00};
    assign pc_out    = pc;

    always_comb begin
        r_result = '0;
        r_valid  = 1'b1;
        case (funct)
            6'h20:   r_result = a + b;
            6'h22:   r_result = a - b;
            6'h24:   r_result = a & b;
            6'h25:   r_result = a | b;
            6'h2A:   r_result = {31'b0, ($signed(a) < $signed(b))};
            default: r_valid  = 1'b0;
        endcase
    end

    // The first FETCH after reset spends one cycle raising mem_req, since the bus outputs are registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state         <= FETCH;
            pc            <= RESET_PC;
            ir            <= '0;
            a             <= '0;
            b             <= '0;
            alu_out       <= '0;
            mdr           <= '0;
            dest          <= '0;
            halted        <= 1'b0;
            mem.mem_req   <= 1'b0;
            mem.mem_we    <= 1'b0;
            mem.mem_addr  <= '0;
            mem.mem_wdata <= '0;
            for (int i = 0; i < 32; i++) begin
                rf[i] <= '0;
            end
        end else begin
            case (state)
                FETCH: begin
                    if (!mem.mem_req) begin
                        mem.mem_req  <= 1'b1;
                        mem.mem_we   <= 1'b0;
                        mem.mem_addr <= pc[ADDR_W+1:2];
                    end else if (mem.mem_ready) begin
                        ir          <= mem.mem_rdata;
                        pc          <= pc + 32'd4;
                        mem.mem_req <= 1'b0;
                        state       <= DECODE;
                    end
                end
                DECODE: begin
                    a       <= rf[rs];
                    b       <= rf[rt];
                    alu_out <= pc + {imm_ext[29:0], 2'b00};
                    state   <= EXEC;
                end
                EXEC: begin
                    case (opcode)
                        OP_RTYPE: begin
                            if (r_valid) begin
                                alu_out <= r_result;
                                dest    <= rd;
                                state   <= WB;
                            end else begin
                                halted <= 1'b1;
                                state  <= HALT;
                            end
                        end
                        OP_LW, OP_SW: begin
                            alu_out       <= eff_addr;
                            mem.mem_req   <= 1'b1;
                            mem.mem_we    <= (opcode == OP_SW);
                            mem.mem_addr  <= eff_addr[ADDR_W+1:2];
                            mem.mem_wdata <= b;
                            state         <= MEM;
                        end
                        OP_ADDI: begin
                            if (SUPPORT_ADDI) begin
                                alu_out <= eff_addr;
                                dest    <= rt;
                                state   <= WB;
                            end else begin
                                halted <= 1'b1;
                                state  <= HALT;
                            end
                        end
                        OP_BEQ: begin
                            pc           <= branch_pc;
                            mem.mem_req  <= 1'b1;
                            mem.mem_we   <= 1'b0;
                            mem.mem_addr <= branch_pc[ADDR_W+1:2];
                            state        <= FETCH;
                        end
                        OP_J: begin
                            pc           <= jump_pc;
                            mem.mem_req  <= 1'b1;
                            mem.mem_we   <= 1'b0;
                            mem.mem_addr <= jump_pc[ADDR_W+1:2];
                            state        <= FETCH;
                        end
                        default: begin
                            halted <= 1'b1;
                            state  <= HALT;
                        end
                    endcase
                end
                MEM: begin
                    // A completed store chains straight into the next fetch without dropping mem_req.
                    if (mem.mem_ready) begin
                        if (mem.mem_we) begin
                            mem.mem_we   <= 1'b0;
                            mem.mem_addr <= pc[ADDR_W+1:2];
                            state        <= FETCH;
                        end else begin
                            mdr         <= mem.mem_rdata;
                            dest        <= rt;
                            mem.mem_req <= 1'b0;
                            state       <= WB;
                        end
                    end
                end
                WB: begin
                    if (dest != 5'd0) begin
                        rf[dest] <= (opcode == OP_LW) ? mdr : alu_out;
                    end
                    mem.mem_req  <= 1'b1;
                    mem.mem_we   <= 1'b0;
                    mem.mem_addr <= pc[ADDR_W+1:2];
                    state        <= FETCH;
                end
                HALT: begin
                end
                default: begin
                    halted      <= 1'b1;
                    mem.mem_req <= 1'b0;
                    state       <= HALT;
                end
            endcase
        end
    end
endmodule
